computie_bus_tracer: RTL and testbench

- Second-generation Computie bus snooper: passively samples CB transactions into a circular trace buffer with address/RW trigger, configurable pre-trigger window, and stored R/W flag per record.
- After capture, streams the trace as ASCII over a byte valid/ready port to the comm/UART path.
- Bus inputs are asynchronous and are synchronised into the comm clock domain. Transceiver controls are fixed to receive-only snooping.

---
 rtl/computie_bus_tracer.sv | 210 +++++++++++++++++++++
 tb/tb_computie_bus_tracer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computie_bus_tracer.sv
// computie_bus_tracer: passive Computie bus snooper with triggered circular trace
// buffer and an ASCII dump port (one byte per two cycles at most).
module computie_bus_tracer #(
  parameter int BITWIDTH    = 32,
  parameter int DEPTH       = 64,
  parameter int PRE_TRIGGER = 16
) (
  input  logic                       comm_clock,
  input  logic                       reset_n,
  input  logic                       arm,
  input  logic                       force_trigger,
  input  logic [BITWIDTH-1:0]        trig_addr,
  input  logic [BITWIDTH-1:0]        trig_mask,
  input  logic                       trig_rw_en,
  input  logic                       trig_rw,
  output logic                       armed,
  output logic                       triggered,
  output logic                       done,
  output logic [$clog2(DEPTH):0]     record_count,
  input  logic                       dump_start,
  output logic                       dump_busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  input  logic                       cb_addr_strobe,
  input  logic                       cb_data_strobe,
  input  logic                       cb_read_write,
  input  logic [BITWIDTH-1:0]        cb_addr_data_bus,
  output logic                       send_receive,
  output logic                       data_dir,
  output logic                       ctrl_oe,
  output logic                       alt_ctrl_oe,
  output logic                       alt_ctrl_dir1,
  output logic                       alt_ctrl_dir2,
  output logic                       al_le,
  output logic                       al_oe,
  output logic                       addr_oe,
  output logic                       data_oe
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNW  = AW + 1;
  localparam int H    = BITWIDTH / 4;
  localparam int XW   = $clog2(2 * H + 3);
  localparam int RECW = 1 + 2 * BITWIDTH;
  localparam logic [CNW-1:0] FULL = CNW'(DEPTH);
  localparam logic [CNW-1:0] POST = CNW'(DEPTH - PRE_TRIGGER);
  localparam logic [XW-1:0]  XH   = XW'(H);
  localparam logic [XW-1:0]  XC   = XW'(H + 1);
  localparam logic [XW-1:0]  XD   = XW'(2 * H + 1);
  localparam logic [XW-1:0]  XL   = XW'(2 * H + 2);

  typedef enum logic [1:0] {C_IDLE, C_ARMED, C_TRIG, C_DONE} cap_t;
  typedef enum logic [1:0] {D_IDLE, D_RD, D_EMIT, D_FIN} dump_t;

  assign {send_receive, data_dir, ctrl_oe, alt_ctrl_oe, alt_ctrl_dir1, alt_ctrl_dir2, al_le} = '0;
  assign {al_oe, addr_oe, data_oe} = '1;

  logic [2:0]          as_q, ds_q;
  logic [1:0]          rws_q;
  logic [BITWIDTH-1:0] addr_q;
  logic                rwl_q, have_q, dsl_q;
  logic                as_fall, ds_fall, ds_rise, rec_v;

  assign as_fall = as_q[2] & ~as_q[1];
  assign ds_fall = ds_q[2] & ~ds_q[1];
  assign ds_rise = ~ds_q[2] & ds_q[1];
  assign rec_v   = ~as_fall & dsl_q & ds_rise;

  // A fresh address strobe always wins and discards any half-finished record.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      as_q   <= 3'b111;
      ds_q   <= 3'b111;
      rws_q  <= '0;
      addr_q <= '0;
      rwl_q  <= 1'b0;
      have_q <= 1'b0;
      dsl_q  <= 1'b0;
    end else begin
      as_q  <= {as_q[1:0], cb_addr_strobe};
      ds_q  <= {ds_q[1:0], cb_data_strobe};
      rws_q <= {rws_q[0], cb_read_write};
      if (as_fall) begin
        addr_q <= cb_addr_data_bus;
        rwl_q  <= rws_q[1];
        have_q <= 1'b1;
        dsl_q  <= 1'b0;
      end else if (have_q && ds_fall) begin
        dsl_q <= 1'b1;
      end else if (rec_v) begin
        have_q <= 1'b0;
        dsl_q  <= 1'b0;
      end
    end
  end

  cap_t           cap_q;
  dump_t          d_q;
  logic [AW-1:0]  wr_ptr_q, rd_q;
  logic [CNW-1:0] count_q, post_q, rem_q;
  logic [XW-1:0]  ch_q;
  logic           busy_q, ov_q;
  logic [7:0]     od_q;
  logic [RECW-1:0] mem [DEPTH];
  logic [RECW-1:0] rec_q;
  logic           arm_ok, dump_ok, we, hit;

  assign arm_ok  = arm & ~busy_q;
  assign dump_ok = dump_start & ~arm_ok & (cap_q == C_IDLE || cap_q == C_DONE);
  assign we      = rec_v & ~arm_ok & (cap_q == C_ARMED || cap_q == C_TRIG);
  assign hit     = (((addr_q ^ trig_addr) & trig_mask) == '0) && (!trig_rw_en || rwl_q == trig_rw);

  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_q    <= C_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= '0;
    end else if (arm_ok) begin
      cap_q    <= C_ARMED;
      wr_ptr_q <= '0;
      count_q  <= '0;
      post_q   <= POST;
    end else begin
      if (we) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (count_q != FULL) count_q <= count_q + CNW'(1);
      end
      if (cap_q == C_ARMED && we && hit) begin
        post_q <= POST - CNW'(1);
        cap_q  <= POST == CNW'(1) ? C_DONE : C_TRIG;
      end else if (cap_q == C_ARMED && force_trigger) begin
        cap_q <= C_TRIG;
      end else if (cap_q == C_TRIG && we) begin
        post_q <= post_q - CNW'(1);
        cap_q  <= post_q == CNW'(1) ? C_DONE : C_TRIG;
      end
    end
  end

  always_ff @(posedge comm_clock) begin
    if (we) mem[wr_ptr_q] <= {rwl_q, addr_q, cb_addr_data_bus};
    rec_q <= mem[rd_q];
  end

  logic [XW-1:0] ai, di;
  logic [3:0]    nib;
  logic [7:0]    hex, chr;
  assign ai  = XH - ch_q;
  assign di  = XD - ch_q;
  assign nib = ch_q <= XH ? 4'(rec_q[2*BITWIDTH-1:BITWIDTH] >> {ai, 2'b00})
                          : 4'(rec_q[BITWIDTH-1:0] >> {di, 2'b00});
  assign hex = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
  assign chr = ch_q == '0 ? (rec_q[RECW-1] ? 8'h52 : 8'h57) :
               ch_q == XC ? 8'h3A :
               ch_q == XL ? 8'h0A : hex;

  // D_RD spends one cycle letting the registered read port deliver the record.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      d_q    <= D_IDLE;
      busy_q <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= '0;
      rd_q   <= '0;
      rem_q  <= '0;
      ch_q   <= '0;
    end else begin
      case (d_q)
        D_IDLE: if (dump_ok) begin
          busy_q <= 1'b1;
          rd_q   <= count_q == FULL ? wr_ptr_q : '0;
          rem_q  <= count_q;
          d_q    <= count_q == '0 ? D_FIN : D_RD;
        end
        D_FIN: begin
          busy_q <= 1'b0;
          d_q    <= D_IDLE;
        end
        D_RD: begin
          ch_q <= '0;
          d_q  <= D_EMIT;
        end
        D_EMIT: if (!ov_q) begin
          ov_q <= 1'b1;
          od_q <= chr;
        end else if (out_ready) begin
          ov_q <= 1'b0;
          if (ch_q != XL) ch_q <= ch_q + XW'(1);
          else if (rem_q == CNW'(1)) begin
            busy_q <= 1'b0;
            d_q    <= D_IDLE;
          end else begin
            rd_q  <= rd_q + AW'(1);
            rem_q <= rem_q - CNW'(1);
            d_q   <= D_RD;
          end
        end
      endcase
    end
  end

  assign armed        = cap_q == C_ARMED || cap_q == C_TRIG;
  assign triggered    = cap_q == C_TRIG || cap_q == C_DONE;
  assign done         = cap_q == C_DONE;
  assign record_count = count_q;
  assign dump_busy    = busy_q;
  assign out_valid    = ov_q;
  assign out_data     = od_q;
endmodule

// File: tb/tb_computie_bus_tracer.sv
// tb_computie_bus_tracer: scoreboard bench; a capture model predicts the trace,
// expected dump bytes are queued at dump start and popped on each transfer.
module tb_computie_bus_tracer;
  localparam int DEPTH = 8, PRE = 2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic arm = 0, force_trigger = 0, trig_rw_en = 0, trig_rw = 0, dump_start = 0;
  logic [31:0] trig_addr = '0, trig_mask = '0, bus = '0;
  logic cb_addr_strobe = 1, cb_data_strobe = 1, cb_read_write = 0;
  logic out_ready = 1'b1;
  logic armed, triggered, done, dump_busy, out_valid;
  logic [3:0] record_count;
  logic [7:0] out_data;
  logic send_receive, data_dir, ctrl_oe, alt_ctrl_oe, alt_ctrl_dir1, alt_ctrl_dir2, al_le, al_oe, addr_oe, data_oe;

  computie_bus_tracer #(.BITWIDTH(32), .DEPTH(DEPTH), .PRE_TRIGGER(PRE)) dut (
    .comm_clock(clk), .reset_n(reset_n), .arm(arm), .force_trigger(force_trigger),
    .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw_en(trig_rw_en), .trig_rw(trig_rw),
    .armed(armed), .triggered(triggered), .done(done), .record_count(record_count),
    .dump_start(dump_start), .dump_busy(dump_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .cb_addr_strobe(cb_addr_strobe), .cb_data_strobe(cb_data_strobe),
    .cb_read_write(cb_read_write), .cb_addr_data_bus(bus), .send_receive(send_receive),
    .data_dir(data_dir), .ctrl_oe(ctrl_oe), .alt_ctrl_oe(alt_ctrl_oe), .alt_ctrl_dir1(alt_ctrl_dir1),
    .alt_ctrl_dir2(alt_ctrl_dir2), .al_le(al_le), .al_oe(al_oe), .addr_oe(addr_oe), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  int nchk = 0, nbad = 0;
  int ready_mode = 0;
  int m_st = 0, m_post = 0;
  logic [64:0] m_buf[$];
  logic [7:0] exp_q[$];
  logic prev_x = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  always @(negedge clk) begin
    if (prev_x) chk("gap", out_valid, 0);
    prev_x = out_valid && out_ready && reset_n;
    if (prev_x) begin
      chk("pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("byte", out_data, exp_q.pop_front());
    end
  end

  task automatic drv(input logic a_s, input logic d_s, input logic [31:0] b, input int n);
    cb_addr_strobe = a_s;
    cb_data_strobe = d_s;
    bus = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_rec(input logic rw, input logic [31:0] a, input logic [31:0] d);
    if (m_st == 1 || m_st == 2) begin
      m_buf.push_back({rw, a, d});
      if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
      if (m_st == 1 && ((a ^ trig_addr) & trig_mask) == 0 && (!trig_rw_en || rw == trig_rw)) begin
        m_st = 2;
        m_post = DEPTH - PRE;
      end
      if (m_st == 2) begin
        m_post--;
        if (m_post == 0) m_st = 3;
      end
    end
  endtask

  task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d);
    cb_read_write = rw;
    drv(0, 1, a, 5);
    drv(0, 0, d, 5);
    drv(0, 1, d, 5);
    drv(1, 1, d, 3);
    model_rec(rw, a, d);
  endtask

  task automatic do_arm();
    @(posedge clk); #1;
    arm = 1;
    if (!dump_busy) begin
      m_st = 1;
      m_buf.delete();
      m_post = DEPTH - PRE;
    end
    @(posedge clk); #1;
    arm = 0;
  endtask

  task automatic do_force();
    @(posedge clk); #1;
    force_trigger = 1;
    if (m_st == 1) m_st = 2;
    @(posedge clk); #1;
    force_trigger = 0;
  endtask

  task automatic push_rec(input logic [64:0] r);
    string hx = "0123456789ABCDEF";
    exp_q.push_back(r[64] ? 8'h52 : 8'h57);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hx[r[32+4*i +: 4]]);
    exp_q.push_back(8'h3A);
    for (int i = 7; i >= 0; i--) exp_q.push_back(hx[r[4*i +: 4]]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic dump_begin();
    @(posedge clk); #1;
    if (m_st == 0 || m_st == 3) foreach (m_buf[i]) push_rec(m_buf[i]);
    dump_start = 1;
    @(posedge clk); #1;
    dump_start = 0;
  endtask

  task automatic dump_wait();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!dump_busy) break;
    end
    chk("dump_end", dump_busy, 0);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_status(input string t);
    chk({t, "_armed"}, armed, m_st == 1 || m_st == 2);
    chk({t, "_trig"}, triggered, m_st >= 2);
    chk({t, "_done"}, done, m_st == 3);
    chk({t, "_count"}, record_count, m_buf.size());
  endtask

  task automatic check_reset(input string t);
    check_status(t);
    chk({t, "_valid"}, out_valid, 0);
    chk({t, "_data"}, out_data, 0);
    chk({t, "_busy"}, dump_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d0;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    chk("ties", {send_receive, data_dir, ctrl_oe, alt_ctrl_oe, alt_ctrl_dir1, alt_ctrl_dir2,
                 al_le, al_oe, addr_oe, data_oe}, 10'b0000000111);
    reset_n = 1;
    @(posedge clk); #1;

    // empty dump: one-cycle busy pulse, no bytes
    dump_begin();
    @(negedge clk);
    chk("empty_busy", dump_busy, 1);
    @(negedge clk);
    chk("empty_busy_drop", dump_busy, 0);

    // always-match trigger
    trig_mask = '0;
    do_arm();
    txn(0, 32'h0000_1000, 32'hDEAD_BEEF);
    txn(1, 32'h0000_1004, 32'h1234_5678);
    txn(0, 32'h0000_1008, 32'h0);
    check_status("t1a");
    dump_begin();
    @(negedge clk);
    chk("dump_ignored", dump_busy, 0);
    for (int i = 0; i < 3; i++) txn(1, 32'h2000 + i, 32'hC0DE_0000 + i);
    check_status("t1b");
    dump_wait();
    ready_mode = 0;
    dump_begin();
    dump_wait();
    ready_mode = 1;
    dump_begin();
    dump_wait();

    // address trigger with pre-trigger window and wrap
    trig_addr = 32'h40;
    trig_mask = '1;
    do_arm();
    for (int i = 0; i < 10; i++) txn(0, i, 32'hA500_0000 + i);
    check_status("t2a");
    txn(0, 32'h40, 32'h4040_4040);
    check_status("t2b");
    for (int i = 0; i < 6; i++) txn(1, 32'h100 + i, 32'h5A00_0000 + i);
    check_status("t2c");
    ready_mode = 2;
    dump_begin();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("hold_seen", out_valid, 1);
    d0 = out_data;
    do_arm();
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, d0);
    end
    ready_mode = 1;
    dump_wait();
    check_status("t2d");

    // RW-qualified trigger
    trig_addr = 32'h80;
    trig_rw_en = 1;
    trig_rw = 1;
    do_arm();
    txn(0, 32'h80, 32'h1);
    check_status("t3w");
    txn(1, 32'h80, 32'h2);
    check_status("t3r");

    // reset mid-capture
    cb_read_write = 0;
    drv(0, 1, 32'h9999, 3);
    #2 reset_n = 0;
    #1 m_st = 0;
    m_buf.delete();
    check_reset("rst_cap");
    drv(1, 1, 0, 2);
    @(negedge clk);
    reset_n = 1;
    trig_rw_en = 0;
    trig_mask = '0;
    do_arm();

    // address phases without completed data phase
    drv(0, 1, 32'h7777, 5);
    drv(1, 1, 32'h7777, 5);
    check_status("abort");
    cb_read_write = 1;
    drv(0, 1, 32'hAAAA, 5);
    drv(0, 0, 32'hDDDD_AAAA, 5);
    drv(1, 0, 32'hDDDD_AAAA, 3);
    drv(0, 0, 32'hBBBB, 5);
    drv(0, 1, 32'hBBBB, 5);
    drv(0, 0, 32'hDDDD_BBBB, 5);
    drv(0, 1, 32'hDDDD_BBBB, 5);
    drv(1, 1, 32'hDDDD_BBBB, 3);
    model_rec(1, 32'hBBBB, 32'hDDDD_BBBB);
    check_status("restart");
    for (int i = 0; i < 5; i++) txn(0, 32'h300 + i, 32'h0F0F_0000 + i);
    check_status("t6");
    dump_begin();
    dump_wait();

    // forced trigger
    trig_addr = 32'hFFFF_0000;
    trig_mask = '1;
    do_arm();
    txn(0, 32'h500, 32'h1111_1111);
    txn(1, 32'h504, 32'h2222_2222);
    txn(0, 32'h508, 32'h3333_3333);
    check_status("pre_force");
    do_force();
    check_status("forced");
    for (int i = 0; i < 6; i++) txn(i[0], 32'h600 + i, 32'h7000_0000 + i);
    check_status("force_done");

    // reset mid-dump, then a normal capture
    ready_mode = 0;
    dump_begin();
    repeat (15) @(negedge clk);
    #2 reset_n = 0;
    #1 exp_q.delete();
    m_st = 0;
    m_buf.delete();
    check_reset("rst_dump");
    repeat (2) @(negedge clk);
    reset_n = 1;
    trig_mask = '0;
    do_arm();
    for (int i = 0; i < 6; i++) txn(0, 32'h900 + i, 32'hFEED_0000 + i);
    check_status("post_rst");
    ready_mode = 1;
    dump_begin();
    dump_wait();

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
